// File: rtl/matmul_operand_sp_pkg.sv
// Shared definitions for the matmul operand scratchpad: operand codes,
// address field layout, operand-select struct and FSM state encoding.
package matmul_operand_sp_pkg;

  localparam int OP_W    = 5;
  localparam int IDX_LSB = 5;

  localparam logic [OP_W-1:0] OP_A = 5'b00100;
  localparam logic [OP_W-1:0] OP_B = 5'b01000;
  localparam logic [OP_W-1:0] OP_C = 5'b10000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic is_a;
    logic is_b;
    logic is_c;
    logic valid;
  } op_sel_t;

  // Number of elements per bus word, which is also the matrix dimension.
  function automatic int calc_max_dim(input int bus_w, input int data_w);
    return bus_w / data_w;
  endfunction

endpackage

// File: rtl/matmul_sp_addr_decode.sv
// Address decoder: splits an address into operand-select flags plus the
// A/B row index and the C element index.
module matmul_sp_addr_decode
  import matmul_operand_sp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = 1
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output op_sel_t               sel_o,
  output logic [IDX_W-1:0]      row_o,
  output logic [2*IDX_W-1:0]    elem_o
);

  logic unused_high_bits;

  // Operand code lives in the low field; anything but the three codes is invalid.
  always_comb begin
    sel_o = '0;
    case (addr_i[OP_W-1:0])
      OP_A:    sel_o.is_a = 1'b1;
      OP_B:    sel_o.is_b = 1'b1;
      OP_C:    sel_o.is_c = 1'b1;
      default: sel_o = '0;
    endcase
    sel_o.valid = sel_o.is_a | sel_o.is_b | sel_o.is_c;
  end

  assign row_o  = addr_i[IDX_LSB +: IDX_W];
  assign elem_o = addr_i[IDX_LSB +: 2*IDX_W];

  assign unused_high_bits = ^addr_i[ADDR_WIDTH-1:IDX_LSB+2*IDX_W];

endmodule

// File: rtl/matmul_operand_sp.sv
// Operand/result scratchpad for the matmul calc unit: host load/readback,
// lock-step A/B/C streaming, C write-back and run sequencing.
module matmul_operand_sp
  import matmul_operand_sp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  host_wr_i,
  input  logic                  host_rd_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [BUS_WIDTH-1:0]  host_wdata_i,
  output logic [BUS_WIDTH-1:0]  host_rdata_o,
  output logic                  host_rvalid_o,
  output logic                  host_err_o,
  input  logic                  go_i,
  output logic                  start_o,
  input  logic                  finish_mul_i,
  input  logic [BUS_WIDTH-1:0]  flags_i,
  output logic [BUS_WIDTH-1:0]  flags_o,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [BUS_WIDTH-1:0]  data_i,
  input  logic                  enable_w_i,
  output logic [BUS_WIDTH-1:0]  data_a_o,
  output logic [BUS_WIDTH-1:0]  data_b_o,
  output logic [BUS_WIDTH-1:0]  data_c_o
);

  localparam int MAX_DIM  = calc_max_dim(BUS_WIDTH, DATA_WIDTH);
  localparam int IDX_W    = $clog2(MAX_DIM);
  localparam int CIDX_W   = 2 * IDX_W;
  localparam int C_WORDS  = MAX_DIM * MAX_DIM;
  localparam int WR_CNT_W = CIDX_W + 1;

  localparam logic [IDX_W-1:0]    ROW_LAST  = IDX_W'(MAX_DIM - 1);
  localparam logic [CIDX_W-1:0]   ELEM_LAST = CIDX_W'(C_WORDS - 1);
  localparam logic [WR_CNT_W-1:0] WR_FULL   = WR_CNT_W'(C_WORDS);
  localparam logic [WR_CNT_W-1:0] WR_SAT    = {WR_CNT_W{1'b1}};

  logic [BUS_WIDTH-1:0] a_q [MAX_DIM];
  logic [BUS_WIDTH-1:0] a_d [MAX_DIM];
  logic [BUS_WIDTH-1:0] b_q [MAX_DIM];
  logic [BUS_WIDTH-1:0] b_d [MAX_DIM];
  logic [BUS_WIDTH-1:0] c_q [C_WORDS];
  logic [BUS_WIDTH-1:0] c_d [C_WORDS];

  logic [IDX_W-1:0]     row_cnt_q, row_cnt_d;
  logic [CIDX_W-1:0]    c_cnt_q, c_cnt_d;
  logic [WR_CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [1:0]           state_q, state_d;
  logic [BUS_WIDTH-1:0] flags_q, flags_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 err_q, err_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 done_err_s;

  op_sel_t              h_sel;
  logic [IDX_W-1:0]     h_row;
  logic [CIDX_W-1:0]    h_elem;
  op_sel_t              calc_sel;
  logic [IDX_W-1:0]     calc_row;
  logic [CIDX_W-1:0]    calc_elem;
  logic                 calc_wr_c;
  logic                 unused_calc;

  matmul_sp_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .IDX_W(IDX_W)) u_host_dec (
    .addr_i (host_addr_i),
    .sel_o  (h_sel),
    .row_o  (h_row),
    .elem_o (h_elem)
  );

  matmul_sp_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .IDX_W(IDX_W)) u_calc_dec (
    .addr_i (address_i),
    .sel_o  (calc_sel),
    .row_o  (calc_row),
    .elem_o (calc_elem)
  );

  assign calc_wr_c   = enable_w_i & calc_sel.is_c;
  assign unused_calc = ^{calc_sel, calc_row};

  // Free-running stream counters, never touched by go_i so they track the calc unit.
  always_comb begin
    if (row_cnt_q == ROW_LAST) begin
      row_cnt_d = '0;
    end else begin
      row_cnt_d = row_cnt_q + IDX_W'(1);
    end
    if (c_cnt_q == ELEM_LAST) begin
      c_cnt_d = '0;
    end else begin
      c_cnt_d = c_cnt_q + CIDX_W'(1);
    end
  end

  // Storage updates and host readback; the calc write is applied last so it wins a collision.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    err_d    = done_err_s;
    rdata_d  = '0;
    rvalid_d = host_rd_i;
    if (host_wr_i) begin
      if ((state_q == ST_RUN) || !h_sel.valid) begin
        err_d = 1'b1;
      end else if (h_sel.is_a) begin
        a_d[h_row] = host_wdata_i;
      end else if (h_sel.is_b) begin
        b_d[h_row] = host_wdata_i;
      end else if (calc_wr_c && (calc_elem == h_elem)) begin
        err_d = 1'b1;
      end else begin
        c_d[h_elem] = host_wdata_i;
      end
    end else begin
      rdata_d = '0;
    end
    if (calc_wr_c) begin
      c_d[calc_elem] = data_i;
    end else begin
      rvalid_d = host_rd_i;
    end
    if (host_rd_i && h_sel.valid) begin
      if (h_sel.is_a) begin
        rdata_d = a_q[h_row];
      end else if (h_sel.is_b) begin
        rdata_d = b_q[h_row];
      end else begin
        rdata_d = c_q[h_elem];
      end
    end else if (host_rd_i) begin
      err_d = 1'b1;
    end else begin
      rdata_d = '0;
    end
  end

  // Run sequencer; wr_cnt saturates so an over-long run is still flagged.
  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    done_err_s = 1'b0;
    if (calc_wr_c && (wr_cnt_q != WR_SAT)) begin
      wr_cnt_d = wr_cnt_q + WR_CNT_W'(1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (go_i) begin
          state_d  = ST_RUN;
          wr_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (finish_mul_i) begin
          state_d    = ST_DONE;
          flags_d    = flags_i;
          done_err_s = (wr_cnt_d != WR_FULL);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    start_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  // Operand storage, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_DIM; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int j = 0; j < C_WORDS; j++) begin
        c_q[j] <= '0;
      end
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_cnt_q <= '0;
      c_cnt_q   <= '0;
      wr_cnt_q  <= '0;
      state_q   <= ST_IDLE;
      flags_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      row_cnt_q <= row_cnt_d;
      c_cnt_q   <= c_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      state_q   <= state_d;
      flags_q   <= flags_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign host_rdata_o  = rdata_q;
  assign host_rvalid_o = rvalid_q;
  assign host_err_o    = err_q;
  assign start_o       = start_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign flags_o       = flags_q;
  assign data_a_o      = a_q[row_cnt_q];
  assign data_b_o      = b_q[row_cnt_q];
  assign data_c_o      = c_q[c_cnt_q];

endmodule
